word_array_ctrl: RTL

Sequential word-array stage directly downstream of the N-to-2^N address decoder. It consumes the decoder's one-hot word select lines and owns an N×W register array. Accesses are single-word reads or writes under a req/ack handshake. Any select vector that is not exactly one-hot is rejected with an error flag, and the array is left untouched.

---
 rtl/word_array_pkg.sv | 17 +
 rtl/onehot_check.sv | 34 +++
 rtl/word_array_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/word_array_pkg.sv
// word_array_pkg
// Shared definitions for the word-array stage that sits behind the address
// decoder: default array geometry and the access FSM state encoding.
package word_array_pkg;

  // Default geometry: number of words (also select-bus width) and word width.
  localparam int DEFAULT_N = 16;
  localparam int DEFAULT_W = 8;

  // Access FSM state encoding, kept as plain constants so the encoding is
  // visible and stable on the debug port.
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

endpackage

// File: rtl/onehot_check.sv
// onehot_check
// Combinational classifier for a word-select vector.
// Ports:
//   sel       - select vector from the capture register
//   is_onehot - high when exactly one bit of sel is set
//   idx       - position of the set bit; meaningful only when is_onehot = 1
module onehot_check #(
  parameter int N = 16
) (
  input  logic [N-1:0]         sel,
  output logic                 is_onehot,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDXW = $clog2(N);

  int unsigned w_cnt;

  // idx is the OR of the positions of all set bits. For a one-hot vector this
  // is exactly the position; for any other vector it is garbage, but callers
  // only use it when is_onehot is high.
  always_comb begin
    w_cnt = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        w_cnt = w_cnt + 1;
        idx   = idx | IDXW'(i);
      end
    end
    is_onehot = (w_cnt == 1);
  end

endmodule

// File: rtl/word_array_ctrl.sv
// word_array_ctrl
// N x W register array addressed by one-hot word select lines, accessed one
// word at a time under a req/ack handshake.
//
// Handshake: req (with we, wr_data, word_select_lines) is sampled only when
// busy = 0. A sampled request completes with a single-cycle ack two cycles
// later; err is valid only while ack is high. All inputs are ignored while
// busy = 1. Holding req high starts a new access on the first idle cycle.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   word_select_lines - one-hot word select (N bits)
//   req, we, wr_data  - access request, 1 = write, write data
//   ack               - one-cycle completion pulse
//   rd_data           - last successful read value (held)
//   err               - select vector was not one-hot (valid with ack)
//   busy              - access in flight
//   o_dbg_state       - current FSM state
module word_array_ctrl
  import word_array_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] word_select_lines,
  input  logic         req,
  input  logic         we,
  input  logic [W-1:0] wr_data,
  output logic         ack,
  output logic [W-1:0] rd_data,
  output logic         err,
  output logic         busy,
  output state_t       o_dbg_state
);

  state_t               r_state;
  logic [N-1:0]         r_sel;
  logic                 r_we;
  logic [W-1:0]         r_wd;
  logic                 r_err;
  logic [W-1:0]         r_rd_data;
  logic [W-1:0]         r_mem [N];

  logic                 w_onehot;
  logic [$clog2(N)-1:0] w_idx;

  // Classification works on the captured vector, so the live select lines
  // cannot influence an access once it is in flight.
  onehot_check #(.N(N)) u_onehot_check (
    .sel       (r_sel),
    .is_onehot (w_onehot),
    .idx       (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_wd      <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_sel   <= word_select_lines;
            r_we    <= we;
            r_wd    <= wr_data;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_onehot) begin
            if (r_we) begin
              r_mem[w_idx] <= r_wd;
            end else begin
              r_rd_data <= r_mem[w_idx];
            end
          end else begin
            // Bad select: array and rd_data are left untouched.
            r_err <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded purely from registered state and flags.
  assign ack         = (r_state == RESP);
  assign err         = (r_state == RESP) && r_err;
  assign busy        = (r_state != IDLE);
  assign rd_data     = r_rd_data;
  assign o_dbg_state = r_state;

endmodule
